ram_portb_sched: RTL and testbench

//  Scheduler for RAM port B (CLK_50 domain). Shares the port between three requesters:
//  - VGA pixel fetch (real-time, highest priority)
//  - a zero-fill clear engine (replaces the wren_b=~resetN hack)
//  - a debug read port (req/gnt handshake)

---
 rtl/ram_sched_pkg.sv | 15 +
 rtl/ram_clear_engine.sv | 59 +++++
 rtl/ram_portb_sched.sv | 104 ++++++++++
 tb/tb_ram_portb_sched.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_sched_pkg.sv
// Shared types and constants for the RAM port B scheduler.
`timescale 1ns/1ps
package ram_sched_pkg;

  typedef enum logic [1:0] {CLR_IDLE, CLR_RUN, CLR_DONE} clr_state_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_VGA, GNT_CLR, GNT_DBG} grant_t;

  localparam int STAT_WIDTH = 16;

  // Saturating increment for the statistics counters.
  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ram_clear_engine.sv
// Zero-fill sweep engine: walks clr_cnt over the whole address space,
// advancing only on cycles where the arbiter grants it the port.
`timescale 1ns/1ps
module ram_clear_engine #(
  parameter int ADDR_WIDTH     = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  grant,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] addr
);
  import ram_sched_pkg::*;

  clr_state_t state;

  // Sweep FSM; busy/done are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR_ON_RESET ? CLR_RUN : CLR_IDLE;
      busy  <= CLEAR_ON_RESET;
      done  <= 1'b0;
      addr  <= '0;
    end else begin
      case (state)
        CLR_IDLE: begin
          if (start) begin
            state <= CLR_RUN;
            busy  <= 1'b1;
            addr  <= '0;
          end
        end
        CLR_RUN: begin
          if (grant) begin
            addr <= addr + 1'b1;
            if (addr == '1) begin
              state <= CLR_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        CLR_DONE: begin
          state <= CLR_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= CLR_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ram_portb_sched.sv
// RAM port B scheduler: fixed-priority VGA > clear > debug arbitration.
// Optional statistics counters are built when RAM_SCHED_STATS_EN is defined.
`timescale 1ns/1ps
module ram_portb_sched #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  CLK_50,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] vga_addr,
  input  logic                  vga_blank,
  output logic [DATA_WIDTH-1:0] vga_data,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  clear_done,
  input  logic                  dbg_req,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr_b,
  output logic [DATA_WIDTH-1:0] ram_data_b,
  output logic                  ram_wren_b,
  input  logic [DATA_WIDTH-1:0] ram_q_b,
  output logic [15:0]           stat_clr_cyc,
  output logic [15:0]           stat_dbg_wait
);
  import ram_sched_pkg::*;

  grant_t                grant;
  logic [ADDR_WIDTH-1:0] clr_addr;

  ram_clear_engine #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear (
    .clk   (CLK_50),
    .reset (reset),
    .start (clear_start),
    .grant (grant == GNT_CLR),
    .busy  (clear_busy),
    .done  (clear_done),
    .addr  (clr_addr)
  );

  // Fixed-priority grant; reset forces the idle/VGA view of the port.
  always_comb begin
    grant = GNT_NONE;
    if (!reset) begin
      if (!vga_blank)     grant = GNT_VGA;
      else if (clear_busy) grant = GNT_CLR;
      else if (dbg_req)    grant = GNT_DBG;
    end
  end

  // Port B address mux follows the grant.
  always_comb begin
    ram_addr_b = vga_addr;
    case (grant)
      GNT_CLR: ram_addr_b = clr_addr;
      GNT_DBG: ram_addr_b = dbg_addr;
      default: ram_addr_b = vga_addr;
    endcase
  end

  assign ram_wren_b = (grant == GNT_CLR);
  assign ram_data_b = '0;
  assign dbg_gnt    = (grant == GNT_DBG);
  assign vga_data   = ram_q_b;

  // Debug read pipeline: rvalid trails the grant by one cycle, data is latched on rvalid.
  always_ff @(posedge CLK_50) begin
    if (reset) begin
      dbg_rvalid <= 1'b0;
      dbg_rdata  <= '0;
    end else begin
      dbg_rvalid <= dbg_gnt;
      if (dbg_rvalid) dbg_rdata <= ram_q_b;
    end
  end

`ifdef RAM_SCHED_STATS_EN
  logic sweep_start;
  // An accepted clear_start is one seen while neither busy nor in the done cycle.
  assign sweep_start = clear_start && !clear_busy && !clear_done;

  // Saturating clear-cycle and debug-wait counters.
  always_ff @(posedge CLK_50) begin
    if (reset) begin
      stat_clr_cyc  <= '0;
      stat_dbg_wait <= '0;
    end else begin
      if (sweep_start)     stat_clr_cyc <= '0;
      else if (clear_busy) stat_clr_cyc <= sat_inc(stat_clr_cyc);
      if (dbg_req && !dbg_gnt) stat_dbg_wait <= sat_inc(stat_dbg_wait);
    end
  end
`else
  assign stat_clr_cyc  = '0;
  assign stat_dbg_wait = '0;
`endif

endmodule

// File: tb/tb_ram_portb_sched.sv
// Self-checking bench for ram_portb_sched with a behavioural RAM and reference model.
`timescale 1ns/1ps
module tb_ram_portb_sched;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] vga_addr;
  logic          vga_blank;
  logic [DW-1:0] vga_data;
  logic          clear_start;
  logic          clear_busy;
  logic          clear_done;
  logic          dbg_req;
  logic [AW-1:0] dbg_addr;
  logic          dbg_gnt;
  logic          dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic [AW-1:0] ram_addr_b;
  logic [DW-1:0] ram_data_b;
  logic          ram_wren_b;
  logic [DW-1:0] ram_q_b;
  logic [15:0]   stat_clr_cyc;
  logic [15:0]   stat_dbg_wait;

  always #5 clk = ~clk;

  ram_portb_sched #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .CLEAR_ON_RESET (1)
  ) dut (
    .CLK_50        (clk),
    .reset         (reset),
    .vga_addr      (vga_addr),
    .vga_blank     (vga_blank),
    .vga_data      (vga_data),
    .clear_start   (clear_start),
    .clear_busy    (clear_busy),
    .clear_done    (clear_done),
    .dbg_req       (dbg_req),
    .dbg_addr      (dbg_addr),
    .dbg_gnt       (dbg_gnt),
    .dbg_rvalid    (dbg_rvalid),
    .dbg_rdata     (dbg_rdata),
    .ram_addr_b    (ram_addr_b),
    .ram_data_b    (ram_data_b),
    .ram_wren_b    (ram_wren_b),
    .ram_q_b       (ram_q_b),
    .stat_clr_cyc  (stat_clr_cyc),
    .stat_dbg_wait (stat_dbg_wait)
  );

  // Behavioural RAM port B plus write log.
  logic [DW-1:0]  mem [DEPTH];
  int unsigned    wr_log[$];
  logic [DW-1:0]  wr_dat[$];
  int             illegal_wr = 0;
  logic           fill_en = 1'b0, pre_en = 1'b0, log_clr = 1'b0;
  logic [AW-1:0]  pre_addr = '0;
  logic [DW-1:0]  pre_data = '0;
  logic           bad_wr;
  assign bad_wr = ram_wren_b && (!vga_blank || reset);

  always @(posedge clk) begin
    ram_q_b <= mem[ram_addr_b];
    if (log_clr) begin
      wr_log.delete();
      wr_dat.delete();
    end
    illegal_wr <= (log_clr ? 0 : illegal_wr) + int'(bad_wr);
    if (fill_en) for (int i = 0; i < DEPTH; i++) mem[i] <= DW'(i) ^ 16'h5A5A;
    if (pre_en) mem[pre_addr] <= pre_data;
    if (ram_wren_b) begin
      mem[ram_addr_b] <= ram_data_b;
      wr_log.push_back(ram_addr_b);
      wr_dat.push_back(ram_data_b);
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  // Expected write log: 0..seg-1 (aborted sweep) followed by a full 0..DEPTH-1 sweep.
  task automatic check_log(input string name, input int seg);
    int bad = 0;
    check({name, "_len"}, wr_log.size(), seg + DEPTH);
    foreach (wr_log[i]) begin
      int e;
      e = (i < seg) ? i : i - seg;
      if (wr_log[i] != e || wr_dat[i] != 0) bad++;
    end
    check({name, "_seq"}, bad, 0);
  endtask

  // Runs cycles 1..N after a caller-prepared cycle 0, bounded at 3000 cycles.
  task automatic sweep_run(input int lo, input int hi, input int reset_n, input int start_a,
                           input int start_b, input bit chk_first,
                           output int done_at, output int done_cnt, output int busy_cnt,
                           output int vga_bad);
    done_at = 0; done_cnt = 0; busy_cnt = 0; vga_bad = 0;
    to_drive();
    reset = 0; clear_start = 0; log_clr = 0; fill_en = 0; pre_en = 0;
    for (int n = 1; n <= 3000; n++) begin
      vga_blank   = !(n >= lo && n < hi);
      vga_addr    = AW'($urandom);
      reset       = (n == reset_n);
      clear_start = (n == start_a) || (n == start_b);
      @(negedge clk);
      if (n == 1 && chk_first) begin
        check("rst_rvalid", dbg_rvalid, 0);
        check("rst_done", clear_done, 0);
        check("rst_rdata", dbg_rdata, 0);
        check("rst_busy", clear_busy, 1);
        check("rst_first_addr", ram_addr_b, 0);
        check("rst_first_wren", ram_wren_b, 1);
      end
      if (!vga_blank && (ram_wren_b || ram_addr_b != vga_addr)) vga_bad++;
      if (clear_busy) busy_cnt++;
      if (clear_done) begin
        done_cnt++;
        if (done_at == 0) done_at = n;
      end
      to_drive();
      if (done_at != 0 && n >= done_at + 8) break;
    end
    if (done_at == 0) $display("FAIL sweep_timeout: no clear_done within 3000 cycles");
    reset = 0; clear_start = 0; vga_blank = 1;
  endtask

  typedef struct {
    logic          blank;
    logic          req;
    logic [AW-1:0] va;
    logic [AW-1:0] da;
    logic          gnt;
    logic          rv;
    logic [AW-1:0] addr;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [9];
    int done_at, done_cnt, busy_cnt, vga_bad, g;
    bit m_busy, m_done, m_rv, gnt_last, e_gnt, e_clr;
    int m_next;
    logic [DW-1:0] m_rdata, m_dq;
    logic [AW-1:0] e_addr;

    // Test 1: one reset cycle, automatic sweep with the port blanked.
    reset = 1; vga_blank = 1; vga_addr = 10'h155; clear_start = 0;
    dbg_req = 0; dbg_addr = '0; fill_en = 1; log_clr = 1;
    @(negedge clk);
    check("rst_gate_wren", ram_wren_b, 0);
    check("rst_gate_addr", ram_addr_b, 10'h155);
    check("rst_gate_gnt", dbg_gnt, 0);
    sweep_run(0, 0, 0, 0, 0, 1, done_at, done_cnt, busy_cnt, vga_bad);
    check("t1_done_cycle", done_at, 1025);
    check("t1_done_count", done_cnt, 1);
    check("t1_busy_cycles", busy_cnt, 1024);
    check("t1_illegal_wr", illegal_wr, 0);
    check_log("t1_log", 0);

    // Test 2: 100 cycles of active video in the middle of a sweep.
    clear_start = 1; log_clr = 1;
    sweep_run(300, 400, 0, 0, 0, 0, done_at, done_cnt, busy_cnt, vga_bad);
    check("t2_done_cycle", done_at, 1125);
    check("t2_done_count", done_cnt, 1);
    check("t2_busy_cycles", busy_cnt, 1124);
    check("t2_vga_view", vga_bad, 0);
    check("t2_illegal_wr", illegal_wr, 0);
    check_log("t2_log", 0);

    // Test 5: reset while clr_cnt is 0x200 restarts the sweep from 0.
    clear_start = 1; log_clr = 1;
    sweep_run(0, 0, 513, 0, 0, 0, done_at, done_cnt, busy_cnt, vga_bad);
    check("t5_done_cycle", done_at, 1538);
    check("t5_done_count", done_cnt, 1);
    check("t5_busy_cycles", busy_cnt, 1537);
    check("t5_illegal_wr", illegal_wr, 0);
    check_log("t5_log", 512);

    // Test 6: clear_start during the sweep and during the done cycle is ignored.
    clear_start = 1; log_clr = 1;
    sweep_run(0, 0, 0, 100, 1025, 0, done_at, done_cnt, busy_cnt, vga_bad);
    check("t6_done_cycle", done_at, 1025);
    check("t6_done_count", done_cnt, 1);
    check("t6_busy_cycles", busy_cnt, 1024);
    check_log("t6_log", 0);
`ifdef RAM_SCHED_STATS_EN
    check("t6_stat_clr_cyc", stat_clr_cyc, 1024);
`endif

    // Test 3: debug read of a preloaded word.
    pre_en = 1; pre_addr = 10'h2A; pre_data = 16'hBEEF;
    to_drive();
    pre_en = 0; vga_blank = 1; dbg_req = 1; dbg_addr = 10'h2A;
    @(negedge clk);
    check("t3_gnt", dbg_gnt, 1);
    check("t3_addr", ram_addr_b, 10'h2A);
    check("t3_wren", ram_wren_b, 0);
    to_drive();
    dbg_req = 0;
    @(negedge clk);
    check("t3_rvalid", dbg_rvalid, 1);
    check("t3_gnt_drop", dbg_gnt, 0);
    to_drive();
    @(negedge clk);
    check("t3_rdata", dbg_rdata, 16'hBEEF);
    check("t3_rvalid_pulse", dbg_rvalid, 0);
    to_drive();

    // Test 4: debug request held through 50 cycles of active video.
    vga_blank = 0; dbg_req = 1; dbg_addr = 10'h2A; g = 0;
    repeat (50) begin
      @(negedge clk);
      if (dbg_gnt) g++;
      to_drive();
    end
    check("t4_no_gnt_active", g, 0);
    vga_blank = 1;
    @(negedge clk);
    check("t4_gnt_on_blank", dbg_gnt, 1);
    to_drive();
    dbg_req = 0;
    @(negedge clk);
    check("t4_rvalid", dbg_rvalid, 1);
`ifdef RAM_SCHED_STATS_EN
    check("t4_stat_dbg_wait", stat_dbg_wait, 50);
`endif
    to_drive();
    @(negedge clk);
    check("t4_rdata", dbg_rdata, 16'hBEEF);
    to_drive();

    // Table: arbitration and back-to-back debug grants with the clear engine idle.
    tbl[0] = '{1'b0, 1'b1, 10'h010, 10'h020, 1'b0, 1'b0, 10'h010};
    tbl[1] = '{1'b1, 1'b1, 10'h011, 10'h020, 1'b1, 1'b0, 10'h020};
    tbl[2] = '{1'b1, 1'b1, 10'h012, 10'h022, 1'b1, 1'b1, 10'h022};
    tbl[3] = '{1'b1, 1'b0, 10'h013, 10'h023, 1'b0, 1'b1, 10'h013};
    tbl[4] = '{1'b0, 1'b0, 10'h3FF, 10'h000, 1'b0, 1'b0, 10'h3FF};
    tbl[5] = '{1'b1, 1'b0, 10'h155, 10'h000, 1'b0, 1'b0, 10'h155};
    tbl[6] = '{1'b0, 1'b1, 10'h2AA, 10'h001, 1'b0, 1'b0, 10'h2AA};
    tbl[7] = '{1'b1, 1'b1, 10'h000, 10'h3FF, 1'b1, 1'b0, 10'h3FF};
    tbl[8] = '{1'b1, 1'b0, 10'h005, 10'h000, 1'b0, 1'b1, 10'h005};
    for (int i = 0; i < 9; i++) begin
      vga_blank = tbl[i].blank; dbg_req = tbl[i].req;
      vga_addr = tbl[i].va; dbg_addr = tbl[i].da;
      @(negedge clk);
      check($sformatf("tbl%0d", i), {dbg_gnt, dbg_rvalid, ram_wren_b, ram_addr_b},
            {tbl[i].gnt, tbl[i].rv, 1'b0, tbl[i].addr});
      to_drive();
    end
    dbg_req = 0; vga_blank = 1;

    // Random phase against the reference model; starts with a reset that launches a sweep.
    m_busy = 0; m_done = 0; m_rv = 0; m_next = 0; m_rdata = '0; m_dq = '0; gnt_last = 0;
    for (int n = 0; n < 6000; n++) begin
      reset       = (n == 0) || ($urandom_range(0, 1499) == 0);
      fill_en     = (n == 0);
      if ($urandom_range(0, 15) == 0) vga_blank = !vga_blank;
      vga_addr    = AW'($urandom);
      clear_start = ($urandom_range(0, 399) == 0);
      if (dbg_req && gnt_last) begin
        if ($urandom_range(0, 1) == 1) dbg_addr = AW'($urandom);
        else dbg_req = 0;
      end else if (!dbg_req && $urandom_range(0, 3) == 0) begin
        dbg_req = 1;
        dbg_addr = AW'($urandom);
      end
      @(negedge clk);
      e_gnt = 0; e_clr = 0; e_addr = vga_addr;
      if (!reset && vga_blank) begin
        if (m_busy) begin
          e_clr = 1;
          e_addr = AW'(m_next);
        end else if (dbg_req) begin
          e_gnt = 1;
          e_addr = dbg_addr;
        end
      end
      check("rand_cycle",
            {ram_addr_b, ram_wren_b, dbg_gnt, clear_busy, clear_done, dbg_rvalid, dbg_rdata},
            {e_addr, e_clr, e_gnt, m_busy, m_done, m_rv, m_rdata});
      gnt_last = dbg_gnt;
      if (reset) begin
        m_busy = 1; m_next = 0; m_done = 0; m_rv = 0; m_rdata = '0;
      end else begin
        if (m_rv) m_rdata = m_dq;
        if (e_gnt) m_dq = mem[dbg_addr];
        m_rv = e_gnt;
        if (m_done) m_done = 0;
        else if (m_busy) begin
          if (e_clr) begin
            if (m_next == DEPTH - 1) begin
              m_busy = 0; m_done = 1; m_next = 0;
            end else m_next++;
          end
        end else if (clear_start) begin
          m_busy = 1; m_next = 0;
        end
      end
      to_drive();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
